// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the tic-tac-toe board painter.
//   - cell codes as stored in the 18-bit game grid
//   - colour constants and the code -> colour map
//   - controller state enum
//   - default board geometry
package board_pkg;

    localparam int PIECE_W_DEF  = 26;
    localparam int GAP_DEF      = 2;
    localparam int ORIGIN_X_DEF = 40;
    localparam int ORIGIN_Y_DEF = 20;
    localparam int NUM_CELLS    = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b11;

    localparam logic [2:0] COLOUR_EMPTY = 3'b000;
    localparam logic [2:0] COLOUR_X     = 3'b100;
    localparam logic [2:0] COLOUR_O     = 3'b001;
    localparam logic [2:0] COLOUR_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAW,
        DONE
    } state_t;

    function automatic logic [2:0] cell_colour(input logic [1:0] code);
        logic [2:0] c;
        case (code)
            CELL_EMPTY: c = COLOUR_EMPTY;
            CELL_X:     c = COLOUR_X;
            CELL_O:     c = COLOUR_O;
            default:    c = COLOUR_RSVD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/board_draw_ctrl_if.sv
// board_draw_ctrl_if: pixel-plot port between the board painter and the
// VGA adapter.
//   x_out, y_out, colour_out, plot : pixel write from the painter
//   hold                           : adapter busy, stalls the painter
// master = painter side, slave = VGA adapter side.
interface board_draw_ctrl_if;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       hold;

    modport master (output x_out, output y_out, output colour_out, output plot,
                    input  hold);
    modport slave  (input  x_out, input  y_out, input  colour_out, input  plot,
                    output hold);
endinterface

// File: rtl/cell_origin.sv
// cell_origin: combinational cell geometry and colour lookup.
//   k      : cell index 0..8, row-major, 0 = top-left
//   code   : 2-bit cell contents
//   cx0    : x of the cell's top-left pixel
//   cy0    : y of the cell's top-left pixel
//   colour : colour for the cell contents
module cell_origin
    import board_pkg::*;
#(
    parameter int PIECE_W  = PIECE_W_DEF,
    parameter int GAP      = GAP_DEF,
    parameter int ORIGIN_X = ORIGIN_X_DEF,
    parameter int ORIGIN_Y = ORIGIN_Y_DEF
) (
    input  logic [3:0] k,
    input  logic [1:0] code,
    output logic [7:0] cx0,
    output logic [6:0] cy0,
    output logic [2:0] colour
);

    localparam logic [7:0] STEP_X = 8'(PIECE_W + GAP);
    localparam logic [6:0] STEP_Y = 7'(PIECE_W + GAP);

    logic [1:0] col;
    logic [1:0] row;

    always_comb begin
        col = 2'd0;
        row = 2'd0;
        case (k)
            4'd0: begin col = 2'd0; row = 2'd0; end
            4'd1: begin col = 2'd1; row = 2'd0; end
            4'd2: begin col = 2'd2; row = 2'd0; end
            4'd3: begin col = 2'd0; row = 2'd1; end
            4'd4: begin col = 2'd1; row = 2'd1; end
            4'd5: begin col = 2'd2; row = 2'd1; end
            4'd6: begin col = 2'd0; row = 2'd2; end
            4'd7: begin col = 2'd1; row = 2'd2; end
            4'd8: begin col = 2'd2; row = 2'd2; end
            default: begin col = 2'd0; row = 2'd0; end
        endcase
    end

    // Sums wrap at the output width, identical to a wider sum truncated.
    assign cx0 = 8'(ORIGIN_X) + (col[1] ? (STEP_X << 1) : 8'd0) + (col[0] ? STEP_X : 8'd0);
    assign cy0 = 7'(ORIGIN_Y) + (row[1] ? (STEP_Y << 1) : 7'd0) + (row[0] ? STEP_Y : 7'd0);
    assign colour = cell_colour(code);

endmodule

// File: rtl/board_draw_ctrl.sv
// board_draw_ctrl: repaints changed tic-tac-toe cells onto the VGA adapter.
//   clk, reset : clock, synchronous active-high reset
//   grid       : 18-bit board, cell k at grid[17-2k:16-2k]
//   start      : pulse requesting a full nine-cell redraw
//   vga        : pixel-plot port (x_out, y_out, colour_out, plot out; hold in)
//   busy       : high whenever a pass is in progress
//   done       : one-cycle pulse at the end of each pass
module board_draw_ctrl
    import board_pkg::*;
#(
    parameter int PIECE_W  = PIECE_W_DEF,
    parameter int GAP      = GAP_DEF,
    parameter int ORIGIN_X = ORIGIN_X_DEF,
    parameter int ORIGIN_Y = ORIGIN_Y_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [17:0]               grid,
    input  logic                      start,
    board_draw_ctrl_if.master         vga,
    output logic                      busy,
    output logic                      done
);

    localparam logic [4:0] PIX_LAST = 5'(PIECE_W - 1);

    state_t      state;
    state_t      state_next;
    logic [17:0] snap;
    logic [17:0] shadow;
    logic [8:0]  dirty;
    logic        force_pending;
    logic [3:0]  k;
    logic [4:0]  px;
    logic [4:0]  py;

    logic [8:0]  diff;
    logic [4:0]  cell_base;
    logic [1:0]  snap_cell;
    logic        pass_req;
    logic        full_req;
    logic        last_pix;
    logic        plot;
    logic [7:0]  cx0;
    logic [6:0]  cy0;
    logic [2:0]  cell_col;

    always_comb begin
        diff = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            diff[i] = grid[16 - 2*i +: 2] != shadow[16 - 2*i +: 2];
        end
    end

    assign cell_base = 5'd16 - {k, 1'b0};
    assign snap_cell = snap[cell_base +: 2];
    // start seen in IDLE is serviced in the same cycle it arrives.
    assign full_req  = force_pending | start;
    assign pass_req  = full_req | (grid != shadow);
    assign last_pix  = (px == PIX_LAST) && (py == PIX_LAST);

    cell_origin #(
        .PIECE_W  (PIECE_W),
        .GAP      (GAP),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_cell_origin (
        .k      (k),
        .code   (snap_cell),
        .cx0    (cx0),
        .cy0    (cy0),
        .colour (cell_col)
    );

    always_comb begin
        state_next = state;
        plot       = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pass_req) state_next = SCAN;
            end
            SCAN: begin
                if (dirty[k])        state_next = DRAW;
                else if (k == 4'd8)  state_next = DONE;
            end
            DRAW: begin
                plot = ~vga.hold;
                if (!vga.hold && last_pix) state_next = (k == 4'd8) ? DONE : SCAN;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign vga.plot       = plot;
    assign vga.x_out      = (state == DRAW) ? cx0 + {3'b000, px} : '0;
    assign vga.y_out      = (state == DRAW) ? cy0 + {2'b00, py}  : '0;
    assign vga.colour_out = (state == DRAW) ? cell_col : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            snap          <= '0;
            shadow        <= '0;
            dirty         <= '0;
            force_pending <= 1'b1;
            k             <= '0;
            px            <= '0;
            py            <= '0;
        end else begin
            state         <= state_next;
            force_pending <= force_pending | start;
            case (state)
                IDLE: begin
                    if (pass_req) begin
                        snap          <= grid;
                        dirty         <= full_req ? '1 : diff;
                        force_pending <= 1'b0;
                        k             <= '0;
                    end
                end
                SCAN: begin
                    if (dirty[k]) begin
                        px <= '0;
                        py <= '0;
                    end else if (k != 4'd8) begin
                        k <= k + 4'd1;
                    end
                end
                DRAW: begin
                    if (!vga.hold) begin
                        if (px == PIX_LAST) begin
                            px <= '0;
                            if (py == PIX_LAST) begin
                                py                  <= '0;
                                shadow[cell_base +: 2] <= snap_cell;
                                if (k != 4'd8) k <= k + 4'd1;
                            end else begin
                                py <= py + 5'd1;
                            end
                        end else begin
                            px <= px + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw_ctrl.sv
// tb_board_draw_ctrl: scoreboard bench for board_draw_ctrl. Expected pixels
// are queued from an independent geometry/colour model and popped by a
// monitor on every plot; each scenario task checks pass timing inline.
module tb_board_draw_ctrl;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] grid;
    logic        busy;
    logic        done;

    board_draw_ctrl_if vga();

    board_draw_ctrl #(
        .PIECE_W  (26),
        .GAP      (2),
        .ORIGIN_X (40),
        .ORIGIN_Y (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .grid  (grid),
        .start (start),
        .vga   (vga),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   plot_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every plot must match the head of the queue.
    always @(negedge clk) begin
        if (vga.plot === 1'b1) begin
            plot_count++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, required no plot",
                         vga.x_out, vga.y_out, vga.colour_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vga.x_out, vga.y_out, vga.colour_out} !== mon_e) begin
                    mismatched++;
                    $display("FAIL plot_pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             vga.x_out, vga.y_out, vga.colour_out, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    function automatic logic [2:0] tb_colour(input logic [1:0] code);
        case (code)
            2'b00:   return 3'b000;
            2'b01:   return 3'b100;
            2'b10:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic push_cell(input int kc, input logic [1:0] code);
        pix_t p;
        for (int py = 0; py < 26; py++) begin
            for (int px = 0; px < 26; px++) begin
                p.x = 8'(40 + (kc % 3) * 28 + px);
                p.y = 7'(20 + (kc / 3) * 28 + py);
                p.c = tb_colour(code);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic push_full(input logic [17:0] g);
        for (int kc = 0; kc < 9; kc++) push_cell(kc, g[16 - 2*kc +: 2]);
    endtask

    task automatic wait_busy(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin t = cyc; return; end
        end
    endtask

    task automatic wait_done(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin t = cyc; return; end
        end
    endtask

    task automatic wait_plots(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (plot_count >= target) begin ok = 1'b1; return; end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic check_pass(input string name, input int t1, input int td, input int want);
        compared++;
        if (t1 < 0 || td < 0 || (td - t1) != want) begin
            mismatched++;
            $display("FAIL %s: busy at %0d done at %0d (delta %0d), required delta %0d",
                     name, t1, td, td - t1, want);
        end
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d pixels never plotted, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int t1, td;
        reset = 1'b1; start = 1'b0; grid = '0; vga.hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({busy, vga.plot, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: busy/plot/done=%b, required 000", {busy, vga.plot, done});
        end
        compared++;
        if ({vga.x_out, vga.y_out, vga.colour_out} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_pixel: x=%0d y=%0d c=%0d, required 0", vga.x_out, vga.y_out, vga.colour_out);
        end
        exp_q.delete();
        push_full(18'h0);
        @(posedge clk); #2 reset = 1'b0;
        wait_busy(10, t1);
        wait_done(7000, td);
        check_pass("reset_full_pass", t1, td, 6093);
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_after: busy=%b, required 0", busy);
        end
        check_drained("reset_drain");
    endtask

    task automatic test_single_cell();
        int t1, td;
        push_cell(4, 2'b01);
        @(posedge clk); #2 grid = 18'h00100;
        wait_busy(10, t1);
        wait_done(2000, td);
        check_pass("single_cell_pass", t1, td, 685);
        check_drained("single_cell_drain");
    endtask

    task automatic test_mid_pass_change();
        int t1, td1, t2, td2;
        bit ok;
        int base;
        push_cell(2, 2'b10);
        push_cell(0, 2'b01);
        base = plot_count;
        @(posedge clk); #2 grid = 18'h02100;
        wait_busy(10, t1);
        wait_plots(base + 1, 200, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL mid_change_draw_start: no plot seen, required plot of cell 2");
        end
        #2 grid = 18'h12100;
        wait_done(2000, td1);
        check_pass("mid_change_first_pass", t1, td1, 685);
        wait_busy(10, t2);
        check_pass("mid_change_restart", td1, t2, 2);
        wait_done(2000, td2);
        check_pass("mid_change_second_pass", t2, td2, 685);
        check_drained("mid_change_drain");
    endtask

    task automatic test_back_to_back();
        int t1, td1, t2, td2;
        bit ok;
        int base;
        push_full(grid);
        push_full(grid);
        base = plot_count;
        pulse_start();
        wait_busy(10, t1);
        wait_plots(base + 8 * 676 + 10, 7000, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL b2b_reach_cell8: plots=%0d, required %0d", plot_count - base, 8 * 676 + 10);
        end
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(2000, td1);
        check_pass("b2b_first_pass", t1, td1, 6093);
        wait_busy(10, t2);
        check_pass("b2b_restart", td1, t2, 2);
        wait_done(7000, td2);
        check_pass("b2b_second_pass", t2, td2, 6093);
        check_drained("b2b_drain");
    endtask

    task automatic test_hold();
        int t1, td;
        bit ok;
        int base;
        pix_t ex;
        push_full(grid);
        base = plot_count;
        pulse_start();
        wait_busy(10, t1);
        wait_plots(base + 100, 1000, ok);
        #2 vga.hold = 1'b1;
        ex = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (vga.plot !== 1'b0 || vga.x_out !== ex.x || vga.y_out !== ex.y) begin
                mismatched++;
                $display("FAIL hold_freeze: cycle %0d plot=%b x=%0d y=%0d, required plot=0 x=%0d y=%0d",
                         i, vga.plot, vga.x_out, vga.y_out, ex.x, ex.y);
            end
        end
        @(posedge clk); #2 vga.hold = 1'b0;
        wait_done(7000, td);
        check_pass("hold_pass", t1, td, 6103);
        check_drained("hold_drain");
    endtask

    task automatic test_reset_mid_draw();
        int t1, td;
        bit ok;
        int base;
        push_full(grid);
        base = plot_count;
        pulse_start();
        wait_plots(base + 50, 1000, ok);
        #2 reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 reset = 1'b0;
        exp_q.delete();
        push_full(grid);
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || vga.plot !== 1'b0 || {vga.x_out, vga.y_out, vga.colour_out} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_mid_draw: busy=%b plot=%b x=%0d y=%0d, required all 0",
                     busy, vga.plot, vga.x_out, vga.y_out);
        end
        wait_busy(10, t1);
        wait_done(7000, td);
        check_pass("reset_mid_redraw", t1, td, 6093);
        check_drained("reset_mid_drain");
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_mid_pass_change();
        test_back_to_back();
        test_hold();
        test_reset_mid_draw();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
